// File: rtl/rom_mult8_sequencer_if.sv
// Request handshake plus ROM read port of the 8x8 ROM-based multiplier.
// master = requester/ROM side, slave = sequencer side.
interface rom_mult8_sequencer_if;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        Ready;
  logic        Done;
  logic [15:0] Product;
  logic        RomEnable;
  logic [7:0]  RomAddress;
  logic [7:0]  RomData;

  modport master (
    output Start, A, B, RomData,
    input  Ready, Done, Product, RomEnable, RomAddress
  );

  modport slave (
    input  Start, A, B, RomData,
    output Ready, Done, Product, RomEnable, RomAddress
  );
endinterface

// File: rtl/rom_mult8_sequencer.sv
// Unsigned 8x8 multiply via four 4x4 ROM lookups; Product at accept+4+ROM_LATENCY edges.
// Start is only taken while Ready (IDLE); requests while busy are dropped, not queued.
module rom_mult8_sequencer #(
  parameter int ROM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  rom_mult8_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                            state;
  logic [7:0]                        a_q;
  logic [7:0]                        b_q;
  logic [1:0]                        cnt;
  logic [1:0]                        acc_cnt;
  logic [15:0]                       acc;
  logic [ROM_LATENCY-1:0]            tag_vld;
  logic [ROM_LATENCY-1:0][1:0]       tag_shf;
  logic [15:0]                       term;
  logic [1:0]                        issue_shf;

  // Shift is carried in nibbles: 0, 1 (x16) or 2 (x256).
  always_comb begin
    issue_shf = {cnt[1] & cnt[0], cnt[1] ^ cnt[0]};
    term      = 16'(bus.RomData) << {tag_shf[ROM_LATENCY-1], 2'b00};
  end

  function automatic logic [7:0] lookup_addr(input logic [1:0] c,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
    logic [3:0] x;
    logic [3:0] y;
    x = c[1] ? a[7:4] : a[3:0];
    y = c[0] ? b[7:4] : b[3:0];
    return {x, y};
  endfunction

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      cnt            <= '0;
      acc_cnt        <= '0;
      acc            <= '0;
      tag_vld        <= '0;
      tag_shf        <= '0;
      bus.Ready      <= 1'b1;
      bus.Done       <= 1'b0;
      bus.Product    <= '0;
      bus.RomEnable  <= 1'b0;
      bus.RomAddress <= '0;
    end else begin
      bus.Done <= 1'b0;

      // The ROM samples the presented address on every ISSUE edge; its tag
      // rides alongside so the data is weighted when it comes back.
      for (int i = ROM_LATENCY - 1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_shf[i] <= tag_shf[i-1];
      end
      tag_vld[0] <= (state == ISSUE);
      tag_shf[0] <= issue_shf;

      if (tag_vld[ROM_LATENCY-1]) begin
        acc     <= acc + term;
        acc_cnt <= acc_cnt + 2'd1;
      end

      case (state)
        IDLE: begin
          if (bus.Start) begin
            a_q            <= bus.A;
            b_q            <= bus.B;
            acc            <= '0;
            acc_cnt        <= '0;
            cnt            <= '0;
            state          <= ISSUE;
            bus.Ready      <= 1'b0;
            bus.RomEnable  <= 1'b1;
            bus.RomAddress <= lookup_addr(2'd0, bus.A, bus.B);
          end
        end
        ISSUE: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state          <= DRAIN;
            bus.RomEnable  <= 1'b0;
            bus.RomAddress <= '0;
          end else begin
            bus.RomAddress <= lookup_addr(cnt + 2'd1, a_q, b_q);
          end
        end
        DRAIN: begin
          if (tag_vld[ROM_LATENCY-1] && acc_cnt == 2'd3) begin
            bus.Product <= acc + term;
            bus.Done    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.Ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
